// File: rtl/resizer_pkg.sv
// Shared definitions for the AXI-Stream resizer: lane field layout helpers
// and the output skid-buffer state encoding.
package resizer_pkg;

   // Lane layout: {last, keep, data[dw-1:0]} with data at the bottom.
   localparam int LANE_DATA_LSB = 0;

   function automatic int lane_keep_bit(input int dw);
      return LANE_DATA_LSB + dw;
   endfunction

   function automatic int lane_last_bit(input int dw);
      return LANE_DATA_LSB + dw + 1;
   endfunction

   function automatic int lane_w(input int dw);
      return dw + 2;
   endfunction

   function automatic int entry_w(input int dw, input int lanes);
      return lane_w(dw) * lanes;
   endfunction

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_t;

endpackage

// File: rtl/resizer_lane_compact.sv
// Packs the kept lanes of one entry toward lane 0 and flags a kept lane
// that follows a last lane within the same entry.
module resizer_lane_compact
   import resizer_pkg::*;
#(
   parameter int M_KEEP_WIDTH = 2,
   parameter int T_DATA_WIDTH = 8
) (
   input  logic [entry_w(T_DATA_WIDTH, M_KEEP_WIDTH)-1:0] entry,
   output logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0]           tdata,
   output logic [M_KEEP_WIDTH-1:0]                        tkeep,
   output logic                                           tlast,
   output logic                                           is_null,
   output logic                                           order_err
);

   localparam int LANE_W        = lane_w(T_DATA_WIDTH);
   localparam int LANE_KEEP_BIT = lane_keep_bit(T_DATA_WIDTH);
   localparam int LANE_LAST_BIT = lane_last_bit(T_DATA_WIDTH);

   logic [T_DATA_WIDTH-1:0] lane_data [M_KEEP_WIDTH];
   logic [M_KEEP_WIDTH-1:0] lane_keep;
   logic [M_KEEP_WIDTH-1:0] lane_last;

   genvar gi;
   generate
      for (gi = 0; gi < M_KEEP_WIDTH; gi++) begin : g_lane
         assign lane_data[gi] = entry[gi*LANE_W + LANE_DATA_LSB +: T_DATA_WIDTH];
         assign lane_keep[gi] = entry[gi*LANE_W + LANE_KEEP_BIT];
         assign lane_last[gi] = entry[gi*LANE_W + LANE_LAST_BIT];
      end
   endgenerate

   always_comb begin
      int  pos;
      logic seen_last;
      pos       = 0;
      seen_last = 1'b0;
      tdata     = '0;
      tkeep     = '0;
      order_err = 1'b0;
      for (int i = 0; i < M_KEEP_WIDTH; i++) begin
         if (lane_keep[i]) begin
            tdata[pos*T_DATA_WIDTH +: T_DATA_WIDTH] = lane_data[i];
            pos = pos + 1;
            // the lane's own last bit does not make its keep an error
            if (seen_last) order_err = 1'b1;
         end
         if (lane_last[i]) seen_last = 1'b1;
      end
      for (int j = 0; j < M_KEEP_WIDTH; j++) begin
         tkeep[j] = (j < pos);
      end
      is_null = (pos == 0);
   end

   assign tlast = |lane_last;

endmodule

// File: rtl/resizer_m_axis_out.sv
// Resizer output stage: compacts buffer entries and drives the AXI-Stream
// master through a 2-deep skid with registered outputs and ready.
module resizer_m_axis_out
   import resizer_pkg::*;
#(
   parameter int M_KEEP_WIDTH = 2,
   parameter int T_DATA_WIDTH = 8,
   parameter int CNT_W        = 16
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           s_entry_valid,
   input  logic [entry_w(T_DATA_WIDTH, M_KEEP_WIDTH)-1:0] s_entry,
   output logic                                           s_entry_ready,
   output logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0]           m_axis_tdata,
   output logic [M_KEEP_WIDTH-1:0]                        m_axis_tkeep,
   output logic                                           m_axis_tlast,
   output logic                                           m_axis_tvalid,
   input  logic                                           m_axis_tready,
   output logic [CNT_W-1:0]                               pkt_count,
   output logic                                           err_last_order,
   input  logic                                           err_clr
);

   localparam int DW = M_KEEP_WIDTH * T_DATA_WIDTH;

   logic [DW-1:0]           beat_data;
   logic [M_KEEP_WIDTH-1:0] beat_keep;
   logic                    beat_last;
   logic                    beat_null;
   logic                    beat_err;

   resizer_lane_compact #(
      .M_KEEP_WIDTH (M_KEEP_WIDTH),
      .T_DATA_WIDTH (T_DATA_WIDTH)
   ) u_compact (
      .entry     (s_entry),
      .tdata     (beat_data),
      .tkeep     (beat_keep),
      .tlast     (beat_last),
      .is_null   (beat_null),
      .order_err (beat_err)
   );

   skid_state_t             state_reg, state_next;
   logic                    ready_reg;
   logic [DW-1:0]           head_data_reg, spare_data_reg;
   logic [M_KEEP_WIDTH-1:0] head_keep_reg, spare_keep_reg;
   logic                    head_last_reg, spare_last_reg;
   logic [CNT_W-1:0]        pkt_count_reg;
   logic                    err_reg;

   logic accept, push, handshake;
   logic load_head, load_spare, head_from_spare;

   assign accept    = s_entry_valid & ready_reg;
   // an empty entry without last carries nothing downstream
   assign push      = accept & ~(beat_null & ~beat_last);
   assign handshake = m_axis_tvalid & m_axis_tready;

   always_comb begin
      state_next      = state_reg;
      load_head       = 1'b0;
      load_spare      = 1'b0;
      head_from_spare = 1'b0;
      case (state_reg)
         SKID_EMPTY: begin
            if (push) begin
               state_next = SKID_ONE;
               load_head  = 1'b1;
            end
         end
         SKID_ONE: begin
            if (push && handshake) begin
               load_head = 1'b1;
            end else if (push) begin
               state_next = SKID_TWO;
               load_spare = 1'b1;
            end else if (handshake) begin
               state_next = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            if (handshake) begin
               state_next      = SKID_ONE;
               head_from_spare = 1'b1;
            end
         end
         default: state_next = SKID_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= SKID_EMPTY;
         ready_reg      <= 1'b0;
         head_data_reg  <= '0;
         head_keep_reg  <= '0;
         head_last_reg  <= 1'b0;
         spare_data_reg <= '0;
         spare_keep_reg <= '0;
         spare_last_reg <= 1'b0;
         pkt_count_reg  <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next != SKID_TWO);
         if (load_head) begin
            head_data_reg <= beat_data;
            head_keep_reg <= beat_keep;
            head_last_reg <= beat_last;
         end else if (head_from_spare) begin
            head_data_reg <= spare_data_reg;
            head_keep_reg <= spare_keep_reg;
            head_last_reg <= spare_last_reg;
         end
         if (load_spare) begin
            spare_data_reg <= beat_data;
            spare_keep_reg <= beat_keep;
            spare_last_reg <= beat_last;
         end
         if (handshake && head_last_reg) pkt_count_reg <= pkt_count_reg + 1'b1;
         // a new error outranks a simultaneous clear
         if (accept && beat_err)   err_reg <= 1'b1;
         else if (err_clr)         err_reg <= 1'b0;
      end
   end

   assign s_entry_ready  = ready_reg;
   assign m_axis_tvalid  = (state_reg != SKID_EMPTY);
   assign m_axis_tdata   = head_data_reg;
   assign m_axis_tkeep   = head_keep_reg;
   assign m_axis_tlast   = head_last_reg;
   assign pkt_count      = pkt_count_reg;
   assign err_last_order = err_reg;

endmodule

// File: tb/tb_resizer_m_axis_out.sv
// Directed bench for resizer_m_axis_out (2 lanes x 8 bits): compaction,
// null entries, backpressure, order error and asynchronous reset.
module tb_resizer_m_axis_out;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_entry_valid;
   logic [19:0] s_entry;
   logic        s_entry_ready;
   logic [15:0] m_axis_tdata;
   logic [1:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [15:0] pkt_count;
   logic        err_last_order;
   logic        err_clr;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   resizer_m_axis_out #(
      .M_KEEP_WIDTH (2),
      .T_DATA_WIDTH (8),
      .CNT_W        (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_entry_valid  (s_entry_valid),
      .s_entry        (s_entry),
      .s_entry_ready  (s_entry_ready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tkeep   (m_axis_tkeep),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .pkt_count      (pkt_count),
      .err_last_order (err_last_order),
      .err_clr        (err_clr)
   );

   // lane = {last, keep, data}; lane 1 in the upper half
   function automatic logic [19:0] mk(input logic k0, input logic l0, input logic [7:0] d0,
                                      input logic k1, input logic l1, input logic [7:0] d1);
      return {l1, k1, d1, l0, k0, d0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one-cycle entry transfer; the stage must be ready when offered
   task automatic send(input logic [19:0] e);
      s_entry       = e;
      s_entry_valid = 1'b1;
      tests_run++;
      if (s_entry_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL send_ready: ready=%b required 1", s_entry_ready);
      end
      step();
      s_entry_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_entry_valid = 1'b0; s_entry = '0;
      m_axis_tready = 1'b0; err_clr = 1'b0;
      step(); step();
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || s_entry_ready !== 1'b0 || pkt_count !== 16'd0 ||
          err_last_order !== 1'b0 || m_axis_tdata !== 16'h0 || m_axis_tkeep !== 2'b00 ||
          m_axis_tlast !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: valid=%b ready=%b cnt=%0d err=%b data=%h keep=%b last=%b required all 0",
                  m_axis_tvalid, s_entry_ready, pkt_count, err_last_order, m_axis_tdata,
                  m_axis_tkeep, m_axis_tlast);
      end
      rst_n = 1'b1;
      step();
      tests_run++;
      if (s_entry_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_ready: ready=%b required 1", s_entry_ready);
      end
      $display("[TB] reset done");
   endtask

   task automatic test_passthrough();
      m_axis_tready = 1'b1;
      send(mk(1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 8'hBB));
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'hBBAA || m_axis_tkeep !== 2'b11 ||
          m_axis_tlast !== 1'b1 || pkt_count !== 16'd0 || err_last_order !== 1'b0) begin
         tests_failed++;
         $display("FAIL passthrough_beat: valid=%b data=%h keep=%b last=%b cnt=%0d err=%b required 1 bbaa 11 1 0 0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, pkt_count, err_last_order);
      end
      step();
      tests_run++;
      if (pkt_count !== 16'd1 || m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL passthrough_count: cnt=%0d valid=%b required 1 0", pkt_count, m_axis_tvalid);
      end
      $display("[TB] passthrough: data=%h keep=%b cnt=%0d", 16'hBBAA, 2'b11, pkt_count);
   endtask

   task automatic test_compaction();
      send(mk(1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22));
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0022 || m_axis_tkeep !== 2'b01 ||
          m_axis_tlast !== 1'b0) begin
         tests_failed++;
         $display("FAIL compact_beat: valid=%b data=%h keep=%b last=%b required 1 0022 01 0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
      end
      step();
      send(mk(1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 8'h44));
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || s_entry_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL null_drop: valid=%b ready=%b required 0 1", m_axis_tvalid, s_entry_ready);
      end
      step();
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || pkt_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL null_drop_after: valid=%b cnt=%0d required 0 1", m_axis_tvalid, pkt_count);
      end
      $display("[TB] compaction and null drop done");
   endtask

   task automatic test_null_last();
      send(mk(1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8'hA5));
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tkeep !== 2'b00 || m_axis_tlast !== 1'b1 ||
          m_axis_tdata !== 16'h0000) begin
         tests_failed++;
         $display("FAIL null_last_beat: valid=%b keep=%b last=%b data=%h required 1 00 1 0000",
                  m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tdata);
      end
      step();
      tests_run++;
      if (pkt_count !== 16'd2) begin
         tests_failed++;
         $display("FAIL null_last_count: cnt=%0d required 2", pkt_count);
      end
      $display("[TB] null-with-last beat cnt=%0d", pkt_count);
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int got  = 0;
      logic acc;
      for (int cyc = 0; cyc < 40; cyc++) begin
         m_axis_tready = (cyc >= 6);
         s_entry_valid = (sent < 5);
         s_entry       = mk(1'b1, 1'b0, 8'(sent + 1), 1'b0, 1'b0, 8'h00);
         if (cyc >= 1 && cyc <= 5) begin
            tests_run++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0001) begin
               tests_failed++;
               $display("FAIL stall_stable: cyc=%0d valid=%b data=%h required 1 0001",
                        cyc, m_axis_tvalid, m_axis_tdata);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            tests_run++;
            if (m_axis_tdata !== 16'(got + 1) || m_axis_tkeep !== 2'b01) begin
               tests_failed++;
               $display("FAIL bp_order: beat=%0d data=%h keep=%b required %h 01",
                        got, m_axis_tdata, m_axis_tkeep, 16'(got + 1));
            end
            $display("[TB] backpressure beat %0d data=%h", got + 1, m_axis_tdata);
            got++;
         end
         acc = s_entry_valid && s_entry_ready;
         step();
         if (acc) sent++;
         if (cyc == 5) begin
            tests_run++;
            if (sent != 2 || s_entry_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL bp_ready_drop: accepted=%0d ready=%b required 2 0", sent, s_entry_ready);
            end
         end
         if (got == 5 && sent == 5) break;
      end
      s_entry_valid = 1'b0;
      tests_run++;
      if (got != 5 || sent != 5 || m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_total: got=%0d sent=%0d valid=%b required 5 5 0", got, sent, m_axis_tvalid);
      end
   endtask

   task automatic test_order_error();
      m_axis_tready = 1'b1;
      send(mk(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 8'h66));
      tests_run++;
      if (err_last_order !== 1'b1 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 ||
          m_axis_tkeep !== 2'b11 || m_axis_tdata !== 16'h6655) begin
         tests_failed++;
         $display("FAIL order_err_set: err=%b valid=%b last=%b keep=%b data=%h required 1 1 1 11 6655",
                  err_last_order, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      tests_run++;
      if (err_last_order !== 1'b0 || pkt_count !== 16'd3) begin
         tests_failed++;
         $display("FAIL order_err_clr: err=%b cnt=%0d required 0 3", err_last_order, pkt_count);
      end
      err_clr = 1'b1;
      send(mk(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h02));
      err_clr = 1'b0;
      tests_run++;
      if (err_last_order !== 1'b1) begin
         tests_failed++;
         $display("FAIL order_err_set_wins: err=%b required 1", err_last_order);
      end
      step();
      tests_run++;
      if (pkt_count !== 16'd4 || m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL order_err_drain: cnt=%0d valid=%b required 4 0", pkt_count, m_axis_tvalid);
      end
      $display("[TB] order error: err=%b cnt=%0d", err_last_order, pkt_count);
   endtask

   task automatic test_async_reset();
      m_axis_tready = 1'b0;
      send(mk(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, 8'h00));
      send(mk(1'b1, 1'b0, 8'hC2, 1'b0, 1'b1, 8'h00));
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || s_entry_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_two_held: valid=%b ready=%b required 1 0", m_axis_tvalid, s_entry_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || pkt_count !== 16'd0 || s_entry_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_immediate: valid=%b cnt=%0d ready=%b required 0 0 0",
                  m_axis_tvalid, pkt_count, s_entry_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      tests_run++;
      if (s_entry_ready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_release: ready=%b valid=%b required 1 0", s_entry_ready, m_axis_tvalid);
      end
      m_axis_tready = 1'b1;
      send(mk(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00));
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0077 || m_axis_tkeep !== 2'b01 ||
          m_axis_tlast !== 1'b1) begin
         tests_failed++;
         $display("FAIL areset_first_beat: valid=%b data=%h keep=%b last=%b required 1 0077 01 1",
                  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
      end
      step();
      tests_run++;
      if (pkt_count !== 16'd1 || m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_count: cnt=%0d valid=%b required 1 0", pkt_count, m_axis_tvalid);
      end
      $display("[TB] async reset recovery cnt=%0d", pkt_count);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_compaction();
      test_null_last();
      test_back_to_back();
      test_order_error();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
